text_plotter: RTL
=================

// Module: text_plotter
// PURPOSE
//  Consumer end of the character-stream/pause protocol driven by the HTML reader.
//  Renders each accepted printable char as an 8x8 glyph on the 320x240 VGA
//  framebuffer, emitting one x/y/colour/plot write per pixel cycle.
//  Throttles the reader with pause while a glyph is drawn.
// PARAMETERS
//  COLS       40      glyph columns per line (320/8)
//  ROWS       30      glyph rows per screen (240/8)
//  FG_COLOUR  3'b000  colour for set font bits
//  BG_COLOUR  3'b111  colour for clear font bits (used only with TEXT_BG_FILL_EN)
// PORTS
//  CLOCK_50      in   1  system clock; all state on rising edge
//  resetn        in   1  asynchronous, active-low reset
//  char_in       in   8  character from reader; meaningful when char_valid=1
//  char_valid    in   1  char_in holds a new character
//  finished      in   1  reader has delivered its last character
//  pause         out  1  1 = reader must hold char_in/char_valid unchanged
//  x             out  9  framebuffer x, 0..319
//  y             out  8  framebuffer y, 0..239
//  colour        out  3  pixel colour
//  plot          out  1  write strobe to VGA adapter, one pixel per cycle
//  done          out  1  sticky: finished seen while IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, col=0, row=0, pause=0, plot=0, x=0, y=0, colour=0, done=0.
//  Reset mid-glyph aborts the glyph; no further plot after resetn falls.
//  pause = (state != IDLE); decoded from state register only, never from inputs.
//  IDLE: char_valid=1 at an edge accepts char_in in that cycle.
//   0x0A -> NEWLINE; 0x20..0x7E -> FETCH; any other code is dropped; stay IDLE.
//  FETCH (1 cycle): issue synchronous font-ROM read, address {char_in[6:0], row_idx}; px=py=0.
//  DRAW (64 cycles): px counts 0..7, then py increments.
//   Registered outputs: x=col*8+px, y=row*8+py.
//   Font bit is MSB-first: px=0 -> bit 7.
//   ROM row for py+1 is prefetched so each pixel takes one cycle.
//   At px=7, py=7 -> ADVANCE.
//  ADVANCE (1 cycle): col+1.
//   If col=COLS-1: col=0, row+1.
//   If row=ROWS-1 also: row wraps to 0 (no scroll, overwrite).
//   -> IDLE.
//  NEWLINE (1 cycle): col=0, row+1 with the same wrap rule -> IDLE.
//  Printable-char latency: accept edge -> first plot 2 cycles later.
//   Busy 66 cycles total; next char may be accepted on the cycle pause drops.
//  Newline: busy 1 cycle, no plot.
//  done: set when finished=1 and state=IDLE; held until reset.
//   A char_valid in that same cycle is still accepted.
//  Width rules: col*8 is a 3-bit left shift, zero-extended to 9 bits.
//   x/y never exceed 319/239 for the default COLS/ROWS.
// CONFIGURATION
//  TEXT_BG_FILL_EN defined:
//   plot=1 on all 64 DRAW cycles; colour=FG_COLOUR for set bits, BG_COLOUR for clear bits.
//  TEXT_BG_FILL_EN undefined:
//   plot=1 only on set bits with colour=FG_COLOUR; plot=0 elsewhere.
//   DRAW still takes exactly 64 cycles.
// STRUCTURE
//  Shared package/header: CHAR_W=8, X_W=9, Y_W=8, COLOUR_W=3, GLYPH_DIM=8,
//   CHAR_NEWLINE=8'h0A, CHAR_FIRST_PRINT=8'h20, CHAR_LAST_PRINT=8'h7E, state encodings.
//  One sub-module: font_rom_8x8.
//   Synchronous 1024x8 ROM, address {code[6:0], row[2:0]}, MIF-initialised.
//  FSM, counters and output registers stay in text_plotter.
// TESTING
//  1. Reset, then 'A' (0x41) with char_valid=1:
//     pause=1 next cycle; first plot at x=0,y=0 two cycles after accept;
//     pixels match font row data; pause=0 after 66 cycles; col=1.
//  2. 40 chars 'B', then 'C':
//     'C' drawn at x=0..7, y=8..15 (column wrap onto row 1).
//  3. 0x0A at col=5, row=2:
//     no plot; pause high 1 cycle; next glyph at x=0, y=24.
//     At row=29, next glyph lands at y=0.
//  4. Chars 0x07 and 0x80: dropped; pause stays 0; no plot; col unchanged.
//  5. Assert resetn=0 at pixel 30 of a glyph:
//     plot=0 and pause=0 immediately; next char drawn at x=0, y=0.
//  6. finished=1 mid-glyph: done=0 until the glyph completes, then 1 and sticky.
//     Repeat with and without TEXT_BG_FILL_EN: space (0x20) gives 64 plots vs 0 plots.

Source files
------------

// File: rtl/text_plotter_pkg.sv
// Shared widths, character codes and FSM encodings for the text plotter.
package text_plotter_pkg;

  localparam int CHAR_W    = 8;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int COLOUR_W  = 3;
  localparam int GLYPH_DIM = 8;

  localparam logic [2:0] GLYPH_LAST = 3'(GLYPH_DIM - 1);

  localparam logic [CHAR_W-1:0] CHAR_NEWLINE     = 8'h0A;
  localparam logic [CHAR_W-1:0] CHAR_FIRST_PRINT = 8'h20;
  localparam logic [CHAR_W-1:0] CHAR_LAST_PRINT  = 8'h7E;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DRAW    = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_NEWLINE = 3'd4;

  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= CHAR_FIRST_PRINT) && (c <= CHAR_LAST_PRINT);
  endfunction

endpackage

// File: rtl/font_rom_8x8.sv
// Synchronous 1024x8 glyph ROM, address {code[6:0], row[2:0]}, data one cycle after address.
// Table stands in for the MIF image: drawn space/A/B/C, generated patterns (MSB set) for other codes.
module font_rom_8x8 (
  input  logic       clk_i,
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0]  data_d;
  logic [7:0]  data_q;
  logic [63:0] glyph;
  logic        use_table;

  always_comb begin
    glyph     = 64'h0;
    use_table = 1'b1;
    case (addr_i[9:3])
      7'h20:   glyph = 64'h0000000000000000;
      7'h41:   glyph = 64'h183C66667E666600;
      7'h42:   glyph = 64'h7C66667C66667C00;
      7'h43:   glyph = 64'h3C66606060663C00;
      default: use_table = 1'b0;
    endcase
    // Row 0 sits in the top byte of each packed glyph.
    if (use_table) data_d = glyph[{~addr_i[2:0], 3'b000} +: 8];
    else           data_d = {1'b1, addr_i[2:0], addr_i[6:3]};
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/text_plotter.sv
// Draws each accepted printable char as an 8x8 glyph, one pixel write per cycle; TEXT_BG_FILL_EN also plots clear bits.
// First plot 2 cycles after accept; pause held 66 cycles per glyph and 1 per newline to stall the reader.
module text_plotter
  import text_plotter_pkg::*;
#(
  parameter int                  COLS      = 40,
  parameter int                  ROWS      = 30,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b000,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b111
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [CHAR_W-1:0]   char_in,
  input  logic                char_valid,
  input  logic                finished,
  output logic                pause,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done
);

  localparam int               COL_W    = $clog2(COLS);
  localparam int               ROW_W    = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [2:0]          state_q,  state_d;
  logic [6:0]          char_q,   char_d;
  logic [COL_W-1:0]    col_q,    col_d;
  logic [ROW_W-1:0]    row_q,    row_d;
  logic [2:0]          px_q,     px_d;
  logic [2:0]          py_q,     py_d;
  logic                done_q,   done_d;
  logic                plot_q,   plot_d;
  logic [X_W-1:0]      x_q,      x_d;
  logic [Y_W-1:0]      y_q,      y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic [ROW_W-1:0] row_next;
  logic [2:0]       rom_row;
  logic [7:0]       rom_data;
  logic             font_bit;

  assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  // Step to the next font row on the last pixel so the ROM latency hides behind it.
  always_comb begin
    rom_row = 3'd0;
    if (state_q == ST_DRAW) rom_row = (px_q == GLYPH_LAST) ? py_q + 3'd1 : py_q;
  end

  font_rom_8x8 u_font_rom (
    .clk_i  (CLOCK_50),
    .addr_i ({char_q, rom_row}),
    .data_o (rom_data)
  );

  assign font_bit = rom_data[~px_q];

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    col_d   = col_q;
    row_d   = row_q;
    px_d    = px_q;
    py_d    = py_q;
    done_d  = done_q | (finished && (state_q == ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (char_valid) begin
          if (char_in == CHAR_NEWLINE) begin
            state_d = ST_NEWLINE;
          end else if (is_printable(char_in)) begin
            state_d = ST_FETCH;
            char_d  = char_in[6:0];
          end
        end
      end
      ST_FETCH: begin
        px_d    = 3'd0;
        py_d    = 3'd0;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        px_d = px_q + 3'd1;
        if (px_q == GLYPH_LAST) begin
          py_d = py_q + 3'd1;
          if (py_q == GLYPH_LAST) state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_next;
        end else begin
          col_d = col_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_NEWLINE: begin
        col_d   = '0;
        row_d   = row_next;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (state_q == ST_DRAW) begin
      x_d      = X_W'({col_q, px_q});
      y_d      = Y_W'({row_q, py_q});
      colour_d = font_bit ? FG_COLOUR : BG_COLOUR;
`ifdef TEXT_BG_FILL_EN
      plot_d   = 1'b1;
`else
      plot_d   = font_bit;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      char_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      col_q    <= col_d;
      row_q    <= row_d;
      px_q     <= px_d;
      py_q     <= py_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign pause  = (state_q != ST_IDLE);
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign done   = done_q;

endmodule
